// File: rtl/relu3_layer_if.sv
// Bus bundle for relu3_layer: control handshake plus the
// source read port and destination write port of the two memories.
interface relu3_layer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 7
);
  logic                     start;
  logic [ADDR_W-1:0]        src_read_addr;
  logic signed [DATA_W-1:0] src_data;
  logic [ADDR_W-1:0]        dst_write_addr;
  logic signed [DATA_W-1:0] dst_data;
  logic                     dst_write_enable;
  logic                     busy;
  logic                     done;
  logic [CNT_W-1:0]         active_count;

  modport master (
    output start, src_data,
    input  src_read_addr, dst_write_addr, dst_data,
    input  dst_write_enable, busy, done, active_count
  );

  modport slave (
    input  start, src_data,
    output src_read_addr, dst_write_addr, dst_data,
    output dst_write_enable, busy, done, active_count
  );
endinterface

// File: rtl/relu3_layer.sv
// Streams layer-3 matmul results through ReLU into the ReLU memory.
// Define LEAKY_RELU_EN to pass negatives as x >>> LEAK_SHIFT instead of 0.
module relu3_layer #(
  parameter int DEPTH      = 64,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic         clk,
  input  logic         reset,
  relu3_layer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t                   state;
  state_t                   state_next;
  logic                     s1_valid;
  logic [ADDR_W-1:0]        s1_addr;
  logic signed [DATA_W-1:0] result;
  logic                     positive;

  assign positive = bus.src_data > 0;

`ifdef LEAKY_RELU_EN
  assign result = bus.src_data[DATA_W-1]
                ? (bus.src_data >>> LEAK_SHIFT)
                : bus.src_data;
`else
  logic unused_leak;
  assign unused_leak = (LEAK_SHIFT != 0);
  assign result = positive ? bus.src_data : '0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (bus.src_read_addr == LAST) state_next = DRAIN;
      // stage 2 empties on the same edge stage 1 was seen empty
      DRAIN:   if (!s1_valid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      s1_valid             <= 1'b0;
      s1_addr              <= '0;
      bus.src_read_addr    <= '0;
      bus.dst_write_addr   <= '0;
      bus.dst_data         <= '0;
      bus.dst_write_enable <= 1'b0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.active_count     <= '0;
    end else begin
      state    <= state_next;
      s1_valid <= (state == RUN);
      s1_addr  <= bus.src_read_addr;

      unique case (state_next)
        RUN: begin
          if (state == RUN)
            bus.src_read_addr <= bus.src_read_addr + 1'b1;
          else
            bus.src_read_addr <= '0;
        end
        DRAIN:   bus.src_read_addr <= bus.src_read_addr;
        default: bus.src_read_addr <= '0;
      endcase

      bus.dst_write_enable <= s1_valid;
      if (s1_valid) begin
        bus.dst_write_addr <= s1_addr;
        bus.dst_data       <= result;
      end

      bus.busy <= (state_next == RUN) || (state_next == DRAIN);
      bus.done <= (state_next == DONE);

      if (state == IDLE && bus.start)
        bus.active_count <= '0;
      else if (s1_valid && positive)
        bus.active_count <= bus.active_count + 1'b1;
    end
  end
endmodule
